// File: rtl/mpu_result_collector_if.sv
// Register-file write port of the MPU result collector: valid/ready handshake plus
// destination row, column and element.
interface mpu_result_collector_if #(
   parameter int unsigned IOW        = 2,
   parameter int unsigned JOW        = 2,
   parameter int unsigned DATA_WIDTH = 32
);
   logic                  reg_write_out;
   logic [IOW-1:0]        reg_i_out;
   logic [JOW-1:0]        reg_j_out;
   logic [DATA_WIDTH-1:0] reg_element_out;
   logic                  reg_ready_in;

   modport master (
      output reg_write_out,
      output reg_i_out,
      output reg_j_out,
      output reg_element_out,
      input  reg_ready_in
   );

   modport slave (
      input  reg_write_out,
      input  reg_i_out,
      input  reg_j_out,
      input  reg_element_out,
      output reg_ready_in
   );
endinterface

// File: rtl/mpu_result_collector.sv
// Collects per-cell FMA results into a pending buffer and drains them round-robin to the
// register file. Optional index transpose is enabled by MPU_COLLECTOR_TRANSPOSE_EN.
module mpu_result_collector #(
   parameter int unsigned ROWS       = 3,
   parameter int unsigned COLS       = 3,
   parameter int unsigned DATA_WIDTH = 32,
   localparam int unsigned IW        = $clog2(ROWS + 1),
   localparam int unsigned JW        = $clog2(COLS + 1)
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            start_in,
   input  logic [IW-1:0]                   m_size_in,
   input  logic [JW-1:0]                   n_size_in,
`ifdef MPU_COLLECTOR_TRANSPOSE_EN
   input  logic                            transpose_in,
`endif
   input  logic [ROWS*COLS-1:0]            ready_in,
   input  logic [ROWS*COLS*DATA_WIDTH-1:0] result_in,
   input  logic                            error_in,
   mpu_result_collector_if.master          wr,
   output logic                            busy_out,
   output logic                            finished_out,
   output logic                            error_out
);

   localparam int unsigned N  = ROWS * COLS;
   localparam int unsigned KW = (N > 1) ? $clog2(N) : 1;
   localparam int unsigned CW = IW + JW;
`ifdef MPU_COLLECTOR_TRANSPOSE_EN
   localparam int unsigned IOW = (IW > JW) ? IW : JW;
   localparam int unsigned JOW = IOW;
`else
   localparam int unsigned IOW = IW;
   localparam int unsigned JOW = JW;
`endif

   typedef enum logic [1:0] {StIdle, StCollect, StDone} state_e;

   state_e                state_q, state_d;
   logic [IW-1:0]         m_q, m_d;
   logic [JW-1:0]         n_q, n_d;
   logic [N-1:0]          pend_q, pend_d;
   logic [DATA_WIDTH-1:0] data_q [N];
   logic [DATA_WIDTH-1:0] data_d [N];
   logic [KW-1:0]         grant_q, grant_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic                  wv_q, wv_d;
   logic [IOW-1:0]        wi_q, wi_d;
   logic [JOW-1:0]        wj_q, wj_d;
   logic [DATA_WIDTH-1:0] we_q, we_d;
   logic                  err_q, err_d;
   logic                  fin_q, fin_d;
   logic                  busy_q, busy_d;
`ifdef MPU_COLLECTOR_TRANSPOSE_EN
   logic                  tr_q, tr_d;
`endif

   logic          start_ok, accept, slot_free, pop, found;
   logic [KW-1:0] sel;
   logic [CW-1:0] target;
   logic [IOW-1:0] sel_i;
   logic [JOW-1:0] sel_j;

   assign start_ok  = (m_size_in != '0) && (m_size_in <= IW'(ROWS)) &&
                      (n_size_in != '0) && (n_size_in <= JW'(COLS));
   assign accept    = wv_q && wr.reg_ready_in;
   assign slot_free = !wv_q || wr.reg_ready_in;
   assign pop       = (state_q == StCollect) && slot_free && found;
   assign target    = CW'(m_q) * CW'(n_q);

   // Round-robin: lowest pending cell at or after last_grant+1, wrapping.
   always_comb begin
      found = 1'b0;
      sel   = '0;
      for (int off = 1; off <= int'(N); off++) begin
         if (!found && pend_q[KW'((int'(grant_q) + off) % int'(N))]) begin
            found = 1'b1;
            sel   = KW'((int'(grant_q) + off) % int'(N));
         end
      end
   end

`ifdef MPU_COLLECTOR_TRANSPOSE_EN
   always_comb begin
      sel_i = IOW'(int'(sel) / int'(COLS));
      sel_j = JOW'(int'(sel) % int'(COLS));
      if (tr_q) begin
         sel_i = IOW'(int'(sel) % int'(COLS));
         sel_j = JOW'(int'(sel) / int'(COLS));
      end
   end
`else
   assign sel_i = IOW'(int'(sel) / int'(COLS));
   assign sel_j = JOW'(int'(sel) % int'(COLS));
`endif

   always_comb begin
      state_d = state_q;
      m_d     = m_q;
      n_d     = n_q;
      pend_d  = pend_q;
      data_d  = data_q;
      grant_d = grant_q;
      cnt_d   = cnt_q;
      wv_d    = wv_q;
      wi_d    = wi_q;
      wj_d    = wj_q;
      we_d    = we_q;
      err_d   = err_q;
`ifdef MPU_COLLECTOR_TRANSPOSE_EN
      tr_d    = tr_q;
`endif
      unique case (state_q)
         StIdle: begin
            wv_d = 1'b0;
            if (start_in) begin
               if (start_ok) begin
                  state_d = StCollect;
                  m_d     = m_size_in;
                  n_d     = n_size_in;
                  pend_d  = '0;
                  cnt_d   = '0;
                  err_d   = 1'b0;
`ifdef MPU_COLLECTOR_TRANSPOSE_EN
                  tr_d    = transpose_in;
`endif
               end else begin
                  state_d = StDone;
                  err_d   = 1'b1;
               end
            end
         end
         StCollect: begin
            if (error_in) err_d = 1'b1;
            if (accept) cnt_d = cnt_q + CW'(1);
            if (slot_free) begin
               wv_d = found;
               if (found) begin
                  pend_d[sel] = 1'b0;
                  we_d        = data_q[sel];
                  wi_d        = sel_i;
                  wj_d        = sel_j;
                  grant_d     = sel;
               end
            end
            // Capture after the pop so a same-cycle re-pulse of the popped cell stays pending.
            for (int k = 0; k < int'(N); k++) begin
               if (ready_in[KW'(k)]) begin
                  if (!((k / int'(COLS) < int'(m_q)) && (k % int'(COLS) < int'(n_q)))) begin
                     err_d = 1'b1;
                  end else if (pend_q[KW'(k)] && !(pop && (sel == KW'(k)))) begin
                     err_d = 1'b1;
                  end else begin
                     pend_d[KW'(k)] = 1'b1;
                     data_d[KW'(k)] = result_in[k*DATA_WIDTH +: DATA_WIDTH];
                  end
               end
            end
            if (accept && ((cnt_q + CW'(1)) == target)) state_d = StDone;
         end
         StDone: begin
            wv_d    = 1'b0;
            state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
      fin_d  = (state_d == StDone);
      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= StIdle;
         m_q     <= '0;
         n_q     <= '0;
         pend_q  <= '0;
         grant_q <= KW'(N - 1);
         cnt_q   <= '0;
         wv_q    <= 1'b0;
         wi_q    <= '0;
         wj_q    <= '0;
         we_q    <= '0;
         err_q   <= 1'b0;
         fin_q   <= 1'b0;
         busy_q  <= 1'b0;
`ifdef MPU_COLLECTOR_TRANSPOSE_EN
         tr_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         m_q     <= m_d;
         n_q     <= n_d;
         pend_q  <= pend_d;
         grant_q <= grant_d;
         cnt_q   <= cnt_d;
         wv_q    <= wv_d;
         wi_q    <= wi_d;
         wj_q    <= wj_d;
         we_q    <= we_d;
         err_q   <= err_d;
         fin_q   <= fin_d;
         busy_q  <= busy_d;
`ifdef MPU_COLLECTOR_TRANSPOSE_EN
         tr_q    <= tr_d;
`endif
      end
   end

   // Payload storage is qualified by pend_q, so it needs no reset.
   always_ff @(posedge clk) begin
      data_q <= data_d;
   end

   assign wr.reg_write_out   = wv_q;
   assign wr.reg_i_out       = wi_q;
   assign wr.reg_j_out       = wj_q;
   assign wr.reg_element_out = we_q;
   assign busy_out           = busy_q;
   assign finished_out       = fin_q;
   assign error_out          = err_q;

endmodule
